// File: rtl/cla_pkg.sv
// Shared definitions for the nibble-serial CLA sequencer: nibble width, FSM state
// encoding and a width helper for index/counter registers.
package cla_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } cla_state_e;

    // Bits needed to index n items; never returns less than 1.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cla_nibble_sequencer_if.sv
// Interfaces of the CLA sequencer: wide operand/result handshake towards the host
// and the nibble operand/sum port towards the 4-bit adder.
interface cla_seq_op_if #(parameter int WIDTH = 16);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, result, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, result, cout, ovf
    );
endinterface

interface cla_seq_add_if
    import cla_pkg::*;
    ;
    logic [NIB_W-1:0] d1;
    logic [NIB_W-1:0] d2;
    logic             Cin;
    logic [NIB_W-1:0] sum;
    logic             Cout;

    modport master (
        output d1, d2, Cin,
        input  sum, Cout
    );

    modport slave (
        input  d1, d2, Cin,
        output sum, Cout
    );
endinterface

// File: rtl/cla_seq_lat_counter.sv
// Loadable down-counter that times the adder latency; o_last marks the cycle in
// which the adder sum is valid and must be sampled.
module cla_seq_lat_counter
    import cla_pkg::*;
#(
    parameter int ADD_LAT = 1,
    parameter int CNT_W   = idx_w(ADD_LAT + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic i_load,
    input  logic i_en,
    output logic o_last
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(ADD_LAT);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= LOAD_VAL;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_last = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/cla_nibble_sequencer.sv
// Nibble-serial wide adder controller driving a fixed 4-bit CLA adder, LSB first.
// Optional subtraction is compiled in with macro CLA_SEQ_SUB_EN.
//
// state | meaning
// IDLE  | ready for an operand pair
// ISSUE | register the current nibble's operands and carry onto the adder port
// WAIT  | adder latency elapses; sum/carry sampled on the last cycle
// DONE  | result presented until the consumer accepts it
module cla_nibble_sequencer
    import cla_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int ADD_LAT = 1
) (
    input  logic         clk,
    input  logic         reset,
    cla_seq_op_if.slave  op_if,
    cla_seq_add_if.master add_if
);

    localparam int NNIB      = WIDTH / NIB_W;
    localparam int NIB_IDX_W = idx_w(NNIB);

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_ISSUE = ST_ISSUE;
    localparam logic [1:0] S_WAIT  = ST_WAIT;
    localparam logic [1:0] S_DONE  = ST_DONE;

    logic [1:0]           r_state;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic                 r_carry;
    logic [NIB_IDX_W-1:0] r_nib;
    logic [NIB_W-1:0]     r_d1;
    logic [NIB_W-1:0]     r_d2;
    logic                 r_cin;
    logic [WIDTH-1:0]     r_result;
    logic                 r_cout;
    logic                 r_ovf;

    logic [WIDTH-1:0]     w_b_eff;
    logic                 w_carry0;
    logic                 w_last;
    logic                 w_last_nib;
    logic [NIB_W-1:0]     w_a_nib;
    logic [NIB_W-1:0]     w_b_nib;
    logic                 w_ovf_next;

`ifdef CLA_SEQ_SUB_EN
    // Subtraction is a + ~b + 1; the caller's carry-in is overridden.
    assign w_b_eff  = op_if.sub ? ~op_if.b : op_if.b;
    assign w_carry0 = op_if.sub ? 1'b1 : op_if.cin;
`else
    logic w_unused_sub;
    assign w_unused_sub = op_if.sub;
    assign w_b_eff      = op_if.b;
    assign w_carry0     = op_if.cin;
`endif

    assign w_a_nib    = r_a[NIB_W*int'(r_nib) +: NIB_W];
    assign w_b_nib    = r_b[NIB_W*int'(r_nib) +: NIB_W];
    assign w_last_nib = (r_nib == NIB_IDX_W'(NNIB - 1));
    // The top nibble's sum carries the result sign bit.
    assign w_ovf_next = (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                        (add_if.sum[NIB_W-1] != r_a[WIDTH-1]);

    cla_seq_lat_counter #(
        .ADD_LAT (ADD_LAT)
    ) u_lat_cnt (
        .clk    (clk),
        .reset  (reset),
        .i_load (r_state == S_ISSUE),
        .i_en   (r_state == S_WAIT),
        .o_last (w_last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_carry  <= 1'b0;
            r_nib    <= '0;
            r_d1     <= '0;
            r_d2     <= '0;
            r_cin    <= 1'b0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (op_if.in_valid) begin
                        r_a     <= op_if.a;
                        r_b     <= w_b_eff;
                        r_carry <= w_carry0;
                        r_nib   <= '0;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_d1    <= w_a_nib;
                    r_d2    <= w_b_nib;
                    r_cin   <= r_carry;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (w_last) begin
                        r_result[NIB_W*int'(r_nib) +: NIB_W] <= add_if.sum;
                        r_carry <= add_if.Cout;
                        if (w_last_nib) begin
                            r_cout  <= add_if.Cout;
                            r_ovf   <= w_ovf_next;
                            r_state <= S_DONE;
                        end else begin
                            r_nib   <= r_nib + 1'b1;
                            r_state <= S_ISSUE;
                        end
                    end
                end
                S_DONE: begin
                    if (op_if.out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign op_if.in_ready  = (r_state == S_IDLE);
    assign op_if.out_valid = (r_state == S_DONE);
    assign op_if.result    = r_result;
    assign op_if.cout      = r_cout;
    assign op_if.ovf       = r_ovf;

    assign add_if.d1  = r_d1;
    assign add_if.d2  = r_d2;
    assign add_if.Cin = r_cin;

endmodule

// File: tb/tb_cla_nibble_sequencer.sv
// Bench for cla_nibble_sequencer (WIDTH=16, ADD_LAT=1) with a behavioural 4-bit adder
// and an arithmetic reference model; covers directed cases plus random operands.
module tb_cla_nibble_sequencer;
    import cla_pkg::*;

    localparam int W   = 16;
    localparam int LAT = 1;
`ifdef CLA_SEQ_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] res;
        logic        co;
        logic        ov;
        logic [15:0] beff;
        logic        c0;
    } ref_t;

    logic clk = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    cla_seq_op_if #(.WIDTH(W)) op_if ();
    cla_seq_add_if             add_if ();

    cla_nibble_sequencer #(.WIDTH(W), .ADD_LAT(LAT)) dut (
        .clk    (clk),
        .reset  (reset),
        .op_if  (op_if),
        .add_if (add_if)
    );

    // Adder whose sum is valid within the cycle its operands are presented.
    logic [4:0] w_add;
    assign w_add       = 5'(add_if.d1) + 5'(add_if.d2) + 5'(add_if.Cin);
    assign add_if.sum  = w_add[3:0];
    assign add_if.Cout = w_add[4];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic ref_t ref_model(input logic [15:0] a, input logic [15:0] b,
                                       input logic c, input logic s);
        ref_t        r;
        logic [16:0] full;
        r.beff = (SUB_EN && s) ? ~b : b;
        r.c0   = (SUB_EN && s) ? 1'b1 : c;
        full   = {1'b0, a} + {1'b0, r.beff} + 17'(r.c0);
        r.res  = full[15:0];
        r.co   = full[16];
        r.ov   = (a[15] == r.beff[15]) && (full[15] != a[15]);
        return r;
    endfunction

    // Carry entering bit 4k of a + beff + c0.
    function automatic logic carry_in(input logic [15:0] a, input logic [15:0] beff,
                                      input logic c0, input int k);
        logic [31:0] mask;
        logic [31:0] s;
        if (k == 0) return c0;
        mask = (32'd1 << (4 * k)) - 32'd1;
        s    = (32'(a) & mask) + (32'(beff) & mask) + 32'(c0);
        return s[4 * k];
    endfunction

    // Follows one operation from its accepting edge through the result handshake.
    task automatic track(input logic [15:0] a, input logic [15:0] b, input logic c,
                         input logic s, input int hold, input bit chain,
                         input logic [15:0] na, input logic [15:0] nb);
        ref_t r;
        int   k;
        r = ref_model(a, b, c, s);
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            if (j == 0) begin
                op_if.in_valid = 1'b0;
                chk("busy", 32'(op_if.in_ready), 32'd0);
            end
            if (j % 2 == 1) begin
                k = j / 2;
                chk($sformatf("d1_n%0d", k), 32'(add_if.d1), 32'(a[4*k +: 4]));
                chk($sformatf("d2_n%0d", k), 32'(add_if.d2), 32'(r.beff[4*k +: 4]));
                chk($sformatf("cin_n%0d", k), 32'(add_if.Cin), 32'(carry_in(a, r.beff, r.c0, k)));
            end
            if (j == 7) chk("early_valid", 32'(op_if.out_valid), 32'd0);
        end
        @(negedge clk);
        chk("out_valid", 32'(op_if.out_valid), 32'd1);
        chk("result", 32'(op_if.result), 32'(r.res));
        chk("cout", 32'(op_if.cout), 32'(r.co));
        chk("ovf", 32'(op_if.ovf), 32'(r.ov));
        if (chain) begin
            op_if.a        = na;
            op_if.b        = nb;
            op_if.cin      = 1'b0;
            op_if.sub      = 1'b0;
            op_if.in_valid = 1'b1;
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", 32'(op_if.out_valid), 32'd1);
            chk("hold_result", 32'(op_if.result), 32'(r.res));
            chk("hold_ready", 32'(op_if.in_ready), 32'd0);
        end
        op_if.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        op_if.out_ready = 1'b0;
        chk("idle_gap", 32'(op_if.in_ready), 32'd1);
        chk("valid_drop", 32'(op_if.out_valid), 32'd0);
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic c,
                          input logic s, input int hold);
        int t;
        t = 0;
        @(negedge clk);
        while (!op_if.in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("ready_wait", 32'(op_if.in_ready), 32'd1);
        op_if.a        = a;
        op_if.b        = b;
        op_if.cin      = c;
        op_if.sub      = s;
        op_if.in_valid = 1'b1;
        @(posedge clk);
        track(a, b, c, s, hold, 1'b0, 16'h0, 16'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        reset           = 1'b0;
        op_if.in_valid  = 1'b0;
        op_if.a         = '0;
        op_if.b         = '0;
        op_if.cin       = 1'b0;
        op_if.sub       = 1'b0;
        op_if.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(op_if.in_ready), 32'd1);
        chk("rst_out_valid", 32'(op_if.out_valid), 32'd0);
        chk("rst_result", 32'(op_if.result), 32'd0);
        chk("rst_cout_ovf", {30'd0, op_if.cout, op_if.ovf}, 32'd0);
        chk("rst_adder_port", {23'd0, add_if.d1, add_if.d2, add_if.Cin}, 32'd0);

        run_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, 0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);

        // Backpressure with a pending request, then accept right after the idle cycle.
        @(negedge clk);
        op_if.a        = 16'h8000;
        op_if.b        = 16'h8000;
        op_if.cin      = 1'b1;
        op_if.sub      = 1'b0;
        op_if.in_valid = 1'b1;
        @(posedge clk);
        track(16'h8000, 16'h8000, 1'b1, 1'b0, 5, 1'b1, 16'hA5A5, 16'h5A5B);
        @(posedge clk);
        track(16'hA5A5, 16'h5A5B, 1'b0, 1'b0, 0, 1'b0, 16'h0, 16'h0);

        // Reset during nibble 2 WAIT discards the operation.
        @(negedge clk);
        op_if.a        = 16'h1111;
        op_if.b        = 16'h2222;
        op_if.cin      = 1'b0;
        op_if.in_valid = 1'b1;
        @(posedge clk);
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            if (j == 0) op_if.in_valid = 1'b0;
        end
        reset = 1'b0;
        #1;
        chk("mid_rst_in_ready", 32'(op_if.in_ready), 32'd1);
        chk("mid_rst_result", 32'(op_if.result), 32'd0);
        chk("mid_rst_adder_port", {23'd0, add_if.d1, add_if.d2, add_if.Cin}, 32'd0);
        chk("mid_rst_out_valid", 32'(op_if.out_valid), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        seen  = 1'b0;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            seen = seen | op_if.out_valid;
        end
        chk("ghost_valid", 32'(seen), 32'd0);

        run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 0);
        run_op(16'h0005, 16'h0003, 1'b0, 1'b1, 0);
        run_op(16'h8000, 16'h0001, 1'b1, 1'b1, 1);

        for (int i = 0; i < 24; i++) begin
            run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/cla_nibble_sequencer.md
# cla_nibble_sequencer

Upstream control stage for the registered 4-bit CLA adder. It accepts WIDTH-bit operand pairs over a valid/ready handshake and issues them to the adder one nibble at a time, LSB first. It chains each nibble's carry-out into the next nibble's carry-in and reassembles the returned sums into a full-width result with carry-out and signed overflow. The adder stays a fixed 4-bit datapath; wide additions become multi-cycle operations.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of 4 and at least 4
- ADD_LAT, 1, adder latency in cycles from operands driven to sum/Cout valid; must be at least 1
- clk  input  1  rising-edge clock, shared with the adder
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  sequencer idle and able to accept
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in of the wide add
- sub  input  1  subtract request; honoured only under the configuration macro
- d1  output  4  adder operand A nibble
- d2  output  4  adder operand B nibble
- Cin  output  1  adder carry-in
- sum  input  4  adder sum
- Cout  input  1  adder carry-out
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  wide sum
- cout  output  1  final carry-out
- ovf  output  1  two's-complement overflow

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- in_ready = (state==IDLE).
- IDLE:
  - On in_valid&&in_ready, capture a, b_eff, and carry (initialised to cin), and set nib=0.
  - Next state is ISSUE.
- ISSUE (one cycle):
  - Register d1=a[4*nib+:4], d2=b_eff[4*nib+:4], Cin=carry.
  - Load the wait counter with ADD_LAT.
  - Next state is WAIT.
- WAIT:
  - d1, d2 and Cin hold their values.
  - The counter decrements each cycle.
  - In the cycle where the counter reaches 1, sample result[4*nib+:4]=sum and carry=Cout.
  - If nib==WIDTH/4-1, go to DONE; otherwise nib++ and go to ISSUE.
- DONE:
  - out_valid=1; cout=carry; ovf=(a[W-1]==b_eff[W-1])&&(result[W-1]!=a[W-1]).
  - result, cout and ovf stay stable until out_ready=1.
  - The cycle after the out_valid&&out_ready handshake, the FSM returns to IDLE.
- Without subtraction enabled, b_eff=b.
- Arithmetic is unsigned modulo 2^WIDTH; cout is bit WIDTH of a+b_eff+cin.

## Timing
- Reset values:
  - state IDLE; in_ready 1.
  - d1, d2, Cin, result, cout, ovf, out_valid all 0.
  - nib 0; wait counter 0.
- Latency: out_valid rises WIDTH/4*(1+ADD_LAT) cycles after the accepting edge. With WIDTH=16 and ADD_LAT=1 that is 8 cycles.
- Throughput: one operation per WIDTH/4*(1+ADD_LAT)+2 cycles. A result handshake always incurs exactly one IDLE cycle before the next accept.
- in_valid is ignored outside IDLE. out_ready is ignored outside DONE.
- Backpressure: DONE holds indefinitely with all outputs stable.
- Reset mid-operation:
  - All state and outputs return to reset values immediately (asynchronously).
  - The in-flight operation is discarded and produces no out_valid.
  - Adder outputs are ignored until the next ISSUE.
- Carry ripple: a carry produced by nibble k is presented on Cin in nibble k+1's ISSUE cycle, never earlier.

## Configuration
- Macro: CLA_SEQ_SUB_EN.
- Defined:
  - When sub=1 is sampled at accept, b_eff=~b and the initial carry is forced to 1 (cin ignored).
  - The result is a-b. cout=1 means no borrow. ovf uses the signed-subtract rule (via b_eff).
- Undefined: the sub port exists but is ignored; the block only adds.

## Structure
- Shared package cla_pkg:
  - NIB_W=4 constant.
  - FSM state enum.
  - Nibble-index and counter width helper (clog2).
- One sub-module: cla_seq_lat_counter, a loadable ADD_LAT down-counter with a "last" flag, used in WAIT.

## Test plan
Default configuration is WIDTH=16, ADD_LAT=1, with the real adder attached.
- Reset release: in_ready=1; out_valid, result, d1, d2, Cin all 0.
- a=0x1234, b=0x0FFF, cin=0 -> result=0x2233, cout=0, ovf=0, with out_valid exactly 8 cycles after accept.
- a=0xFFFF, b=0x0001, cin=0 -> result=0x0000, cout=1, ovf=0. Cin must be 1 in ISSUE of nibbles 1 to 3.
- a=0x7FFF, b=0x0001 -> result=0x8000, ovf=1, cout=0.
- Hold out_ready=0 for 5 cycles in DONE with in_valid=1 -> result stable and no accept. After release, the next accept occurs 1 cycle after the handshake.
- Assert reset during nibble 2 WAIT -> outputs reset immediately. After release, 0x0001+0x0001 -> 0x0002. Under CLA_SEQ_SUB_EN, 0x0005-0x0003 -> 0x0002, cout=1.
